array_divider_pipe: RTL and testbench



---
 rtl/array_divider_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_array_divider_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_divider_pipe.sv
// -----------------------------------------------------------------------------
// array_divider_pipe
//
// Pipelined restoring array divider, signed or unsigned per transaction.
// One quotient bit is resolved per row. There are DATAWIDTH rows and
// DATAWIDTH+1 slot boundaries:
//   - slot 0 holds the preprocessed operands;
//   - slot j holds the output of row j-1.
// The first NUM_PIPELINE_STAGES slots are registers and the rest are plain
// wires. The result therefore appears NUM_PIPELINE_STAGES cycles after
// acceptance.
//
// A single global stall covers the whole pipe:
//   advance = !o_valid | i_ready_out.
// Every enabled slot loads only when advance is 1. Bubbles are kept in place,
// so results leave in issue order.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   i_valid      operand pair valid
//   o_ready_in   divider accepts an operand pair this cycle (== advance)
//   i_signed     1 = two's-complement operands, 0 = unsigned
//   i_tag        user tag, returned unchanged with the result
//   A, B         dividend, divisor
//   o_valid      result valid
//   i_ready_out  consumer accepts the result
//   Q_out, R_out quotient (truncated toward zero), remainder (sign of A)
//   o_tag        tag of the result
//   o_div0       divisor was zero: Q_out = all ones, R_out = A
//   o_ovf        signed most-negative / -1: Q_out = A, R_out = 0
// -----------------------------------------------------------------------------
module array_divider_pipe #(
   parameter int DATAWIDTH           = 8,
   parameter int NUM_PIPELINE_STAGES = 1,
   parameter int TAG_WIDTH           = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 o_ready_in,
   input  logic                 i_signed,
   input  logic [TAG_WIDTH-1:0] i_tag,
   input  logic [DATAWIDTH-1:0] A,
   input  logic [DATAWIDTH-1:0] B,
   output logic                 o_valid,
   input  logic                 i_ready_out,
   output logic [DATAWIDTH-1:0] Q_out,
   output logic [DATAWIDTH-1:0] R_out,
   output logic [TAG_WIDTH-1:0] o_tag,
   output logic                 o_div0,
   output logic                 o_ovf
);

   // ---------------------------------------------------------------------------
   // Parameter legality, checked at elaboration
   // ---------------------------------------------------------------------------
   if (DATAWIDTH < 2) begin : g_bad_width
      $fatal(1, "array_divider_pipe: DATAWIDTH must be >= 2");
   end
   if (TAG_WIDTH < 1) begin : g_bad_tag
      $fatal(1, "array_divider_pipe: TAG_WIDTH must be >= 1");
   end
   if (NUM_PIPELINE_STAGES < 1 || NUM_PIPELINE_STAGES > DATAWIDTH + 1) begin : g_bad_depth
      $fatal(1, "array_divider_pipe: NUM_PIPELINE_STAGES must be in 1..DATAWIDTH+1");
   end

   localparam int DW = DATAWIDTH;
   localparam int NS = NUM_PIPELINE_STAGES;

   localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

   // Everything that travels with one operation from slot to slot.
   //   rem  : partial remainder magnitude
   //   dvd  : dividend magnitude, left-shifted by one bit per row so the next
   //          bit to bring down is always dvd[msb]
   //   quo  : quotient magnitude; one bit is shifted in per row
   //   dvs  : divisor magnitude
   //   a_orig : original A, needed for the divide-by-zero remainder
   typedef struct packed {
      logic [DW-1:0]        rem;
      logic [DW-1:0]        dvd;
      logic [DW-1:0]        quo;
      logic [DW-1:0]        dvs;
      logic [DW-1:0]        a_orig;
      logic [TAG_WIDTH-1:0] tag;
      logic                 sgn;
      logic                 sign_q;
      logic                 sign_r;
      logic                 div0;
      logic                 ovf;
   } slot_t;

   // One restoring-division row. The trial value is DW+1 bits wide so the
   // bit shifted out of the partial remainder still takes part in the compare.
   function automatic slot_t row_step(input slot_t s);
      slot_t         n;
      logic [DW:0]   trial;
      logic          ge;
      n     = s;
      trial = {s.rem, s.dvd[DW-1]};
      ge    = (trial >= {1'b0, s.dvs});
      // When ge is false, trial < dvs < 2^DW, so its top bit is zero.
      n.rem = ge ? DW'(trial - {1'b0, s.dvs}) : trial[DW-1:0];
      n.dvd = s.dvd << 1;
      n.quo = {s.quo[DW-2:0], ge};
      return n;
   endfunction

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic w_advance;

   assign w_advance  = !o_valid || i_ready_out;
   assign o_ready_in = w_advance;

   // ---------------------------------------------------------------------------
   // Preprocess: take magnitudes, capture signs and special-case flags
   // ---------------------------------------------------------------------------
   slot_t w_pre;

   always_comb begin
      logic a_neg;
      logic b_neg;
      // NOTE: every variable written in this block gets a value on every path
      // (here by the unconditional defaults), so no latch is inferred.
      w_pre  = '0;
      a_neg  = i_signed & A[DW-1];
      b_neg  = i_signed & B[DW-1];
      // Negating the most-negative value gives the same bit pattern. Read as
      // an unsigned number, that pattern is the correct magnitude 2^(DW-1).
      w_pre.dvd    = a_neg ? DW'(-A) : A;
      w_pre.dvs    = b_neg ? DW'(-B) : B;
      w_pre.a_orig = A;
      w_pre.tag    = i_tag;
      w_pre.sgn    = i_signed;
      w_pre.sign_q = a_neg ^ b_neg;
      w_pre.sign_r = a_neg;
      w_pre.div0   = (B == '0);
      w_pre.ovf    = i_signed && (A == MOST_NEG) && (B == '1);
   end

   // ---------------------------------------------------------------------------
   // Slot chain
   //   w_in[j]  : value presented to slot j
   //              (preprocess for j = 0, row j-1 output otherwise)
   //   w_slot[j]: value leaving slot j
   //              (the register when enabled, else w_in[j] passed through)
   // ---------------------------------------------------------------------------
   slot_t w_in   [DW+1];
   slot_t w_slot [DW+1];
   logic  w_vin  [DW+1];
   logic  w_vld  [DW+1];

   slot_t r_slot [NS];
   logic  r_vld  [NS];

   assign w_in[0]  = w_pre;
   assign w_vin[0] = i_valid;

   for (genvar j = 1; j <= DW; j++) begin : g_row
      assign w_in[j]  = row_step(w_slot[j-1]);
      assign w_vin[j] = w_vld[j-1];
   end

   for (genvar j = 0; j <= DW; j++) begin : g_slot
      if (j < NS) begin : g_reg
         // Data registers are cleared along with the valid bits. A reset in
         // mid-operation then leaves nothing from the discarded operations.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_vld[j]  <= 1'b0;
               r_slot[j] <= '0;
            end else if (w_advance) begin
               // NOTE: state is updated with non-blocking assignments. Every
               // slot then samples its neighbour's pre-edge value, whatever
               // order the blocks are evaluated in.
               r_vld[j]  <= w_vin[j];
               r_slot[j] <= w_in[j];
            end
         end
         assign w_slot[j] = r_slot[j];
         assign w_vld[j]  = r_vld[j];
      end else begin : g_wire
         assign w_slot[j] = w_in[j];
         assign w_vld[j]  = w_vin[j];
      end
   end

   // ---------------------------------------------------------------------------
   // Postprocess and output gating
   // ---------------------------------------------------------------------------
   // The last enabled slot decides validity. Any slots after it are wires.
   assign o_valid = r_vld[NS-1];

   slot_t         w_fin;
   logic [DW-1:0] w_q;
   logic [DW-1:0] w_r;

   assign w_fin = w_slot[DW];

   always_comb begin
      w_q = (w_fin.sgn && w_fin.sign_q) ? DW'(-w_fin.quo) : w_fin.quo;
      w_r = (w_fin.sgn && w_fin.sign_r) ? DW'(-w_fin.rem) : w_fin.rem;
      if (w_fin.div0) begin
         w_q = '1;
         w_r = w_fin.a_orig;
      end else if (w_fin.ovf) begin
         // Falls out of the magnitude path anyway; kept explicit for clarity.
         w_q = w_fin.a_orig;
         w_r = '0;
      end
   end

   // Results, tag and flags read as zero whenever no result is valid. This
   // also covers the reset state and the data left behind by bubbles.
   always_comb begin
      Q_out  = '0;
      R_out  = '0;
      o_tag  = '0;
      o_div0 = 1'b0;
      o_ovf  = 1'b0;
      if (o_valid) begin
         Q_out  = w_q;
         R_out  = w_r;
         o_tag  = w_fin.tag;
         o_div0 = w_fin.div0;
         o_ovf  = w_fin.ovf && !w_fin.div0;
      end
   end

endmodule

// File: tb/tb_array_divider_pipe.sv
// -----------------------------------------------------------------------------
// tb_array_divider_pipe
//
// Directed checks run on a depth-3 instance: basic issue, signed values,
// special cases, backpressure, and reset in mid-operation. Instances of
// depth 1, 5 and 9 receive the same stimulus. During the random phase they
// are compared cycle by cycle against a behavioural reference, and the
// expected output is taken from the stimulus issued exactly N cycles earlier.
// -----------------------------------------------------------------------------
module tb_array_divider_pipe;

   localparam int HMAX = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_valid;
   logic       i_signed;
   logic [3:0] i_tag;
   logic [7:0] a;
   logic [7:0] b;
   logic       i_ready_out;

   logic       d3_ready;
   logic       d3_valid;
   logic [7:0] d3_q;
   logic [7:0] d3_r;
   logic [3:0] d3_tag;
   logic       d3_div0;
   logic       d3_ovf;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   bit sweep_on = 1'b0;

   bit         hist_v [HMAX];
   bit         hist_s [HMAX];
   logic [7:0] hist_a [HMAX];
   logic [7:0] hist_b [HMAX];
   logic [3:0] hist_t [HMAX];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Behavioural reference: {Q[7:0], R[7:0], div0, ovf}
   function automatic logic [17:0] ref_div(input bit sgn, input logic [7:0] av, input logic [7:0] bv);
      int sa;
      int sb;
      int q;
      int r;
      if (bv == 8'h00) return {8'hFF, av, 1'b1, 1'b0};
      if (sgn) begin
         sa = int'($signed(av));
         sb = int'($signed(bv));
         if (sa == -128 && sb == -1) return {av, 8'h00, 1'b0, 1'b1};
         q = sa / sb;
         r = sa % sb;
         return {q[7:0], r[7:0], 1'b0, 1'b0};
      end
      q = int'(av) / int'(bv);
      r = int'(av) % int'(bv);
      return {q[7:0], r[7:0], 1'b0, 1'b0};
   endfunction

   array_divider_pipe #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(3), .TAG_WIDTH(4)) u_dut3 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready_in(d3_ready),
      .i_signed(i_signed), .i_tag(i_tag), .A(a), .B(b),
      .o_valid(d3_valid), .i_ready_out(i_ready_out),
      .Q_out(d3_q), .R_out(d3_r), .o_tag(d3_tag), .o_div0(d3_div0), .o_ovf(d3_ovf)
   );

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      localparam int N = (g == 0) ? 1 : ((g == 1) ? 5 : 9);
      logic       rdy;
      logic       vld;
      logic [7:0] q;
      logic [7:0] r;
      logic [3:0] tg;
      logic       dz;
      logic       ov;

      array_divider_pipe #(.DATAWIDTH(8), .NUM_PIPELINE_STAGES(N), .TAG_WIDTH(4)) u_dut (
         .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready_in(rdy),
         .i_signed(i_signed), .i_tag(i_tag), .A(a), .B(b),
         .o_valid(vld), .i_ready_out(i_ready_out),
         .Q_out(q), .R_out(r), .o_tag(tg), .o_div0(dz), .o_ovf(ov)
      );

      always @(negedge clk) begin
         if (sweep_on) begin : mon
            int          idx;
            bit          ev;
            logic [17:0] e;
            idx = cyc - N;
            ev  = (idx >= 0 && idx < HMAX) ? hist_v[idx] : 1'b0;
            check($sformatf("N%0d_valid", N), 32'(vld), 32'(ev));
            if (ev && vld) begin
               e = ref_div(hist_s[idx], hist_a[idx], hist_b[idx]);
               check($sformatf("N%0d_q", N),    32'(q),  32'(e[17:10]));
               check($sformatf("N%0d_r", N),    32'(r),  32'(e[9:2]));
               check($sformatf("N%0d_tag", N),  32'(tg), 32'(hist_t[idx]));
               check($sformatf("N%0d_flags", N), 32'({dz, ov}), 32'(e[1:0]));
            end else if (!vld) begin
               check($sformatf("N%0d_idle_flags", N), 32'({dz, ov}), 32'd0);
            end
         end
      end
   end

   // Issue one operation on an empty depth-3 pipe and check its timing and
   // result. Entered and left one time unit after a rising edge.
   task automatic run_one(input string name, input bit sgn, input logic [7:0] av,
                          input logic [7:0] bv, input logic [3:0] tg,
                          input logic [7:0] eq, input logic [7:0] er,
                          input bit ediv0, input bit eovf);
      i_signed    = sgn;
      a           = av;
      b           = bv;
      i_tag       = tg;
      i_valid     = 1'b1;
      i_ready_out = 1'b1;
      @(negedge clk);
      check({name, "_ready_in"}, 32'(d3_ready), 32'd1);
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check({name, "_early_valid"}, 32'(d3_valid), 32'd0);
      end
      @(negedge clk);
      check({name, "_valid"}, 32'(d3_valid), 32'd1);
      check({name, "_q"},     32'(d3_q),     32'(eq));
      check({name, "_r"},     32'(d3_r),     32'(er));
      check({name, "_tag"},   32'(d3_tag),   32'(tg));
      check({name, "_div0"},  32'(d3_div0),  32'(ediv0));
      check({name, "_ovf"},   32'(d3_ovf),   32'(eovf));
      @(posedge clk);
      #1;
   endtask

   // Backpressure vectors: A = 10k+3, B = k+1, unsigned, tag k.
   logic [7:0] bp_q [6] = '{8'd3, 8'd6, 8'd7, 8'd8, 8'd8, 8'd8};
   logic [7:0] bp_r [6] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd3, 8'd5};

   task automatic backpressure();
      fork
         begin : producer
            int k;
            int budget;
            bit rdy;
            k = 0;
            budget = 0;
            while (k < 6 && budget < 40) begin
               i_signed = 1'b0;
               a        = 8'(10 * k + 3);
               b        = 8'(k + 1);
               i_tag    = 4'(k);
               i_valid  = 1'b1;
               @(negedge clk);
               #1 rdy = d3_ready;
               @(posedge clk);
               if (rdy) k++;
               budget++;
               #1;
            end
            i_valid = 1'b0;
            check("bp_all_issued", 32'(k), 32'd6);
         end
         begin : consumer
            int budget;
            int got;
            logic [7:0] snap_q;
            logic [3:0] snap_t;
            i_ready_out = 1'b1;
            budget = 0;
            @(negedge clk);
            while (!d3_valid && budget < 10) begin
               @(negedge clk);
               budget++;
            end
            check("bp_first_valid", 32'(d3_valid), 32'd1);
            i_ready_out = 1'b0;
            snap_q = d3_q;
            snap_t = d3_tag;
            repeat (4) begin
               @(negedge clk);
               check("bp_stall_valid", 32'(d3_valid), 32'd1);
               check("bp_stall_q",     32'(d3_q),     32'(snap_q));
               check("bp_stall_tag",   32'(d3_tag),   32'(snap_t));
               check("bp_stall_ready", 32'(d3_ready), 32'd0);
            end
            i_ready_out = 1'b1;
            got = 0;
            budget = 0;
            while (got < 6 && budget < 30) begin
               if (d3_valid) begin
                  check("bp_order_tag", 32'(d3_tag), 32'(got));
                  check("bp_q", 32'(d3_q), 32'(bp_q[got]));
                  check("bp_r", 32'(d3_r), 32'(bp_r[got]));
                  got++;
               end
               @(negedge clk);
               budget++;
            end
            check("bp_result_count", 32'(got), 32'd6);
            repeat (5) begin
               @(negedge clk);
               check("bp_no_duplicate", 32'(d3_valid), 32'd0);
            end
         end
      join
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < HMAX; i++) hist_v[i] = 1'b0;
      rst = 1'b0;
      i_valid = 1'b0;
      i_signed = 1'b0;
      i_tag = '0;
      a = '0;
      b = '0;
      i_ready_out = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(d3_valid), 32'd0);
      check("rst_q",     32'(d3_q),     32'd0);
      check("rst_r",     32'(d3_r),     32'd0);
      check("rst_tag",   32'(d3_tag),   32'd0);
      check("rst_flags", 32'({d3_div0, d3_ovf}), 32'd0);
      rst = 1'b1;
      #1 check("rst_ready_after", 32'(d3_ready), 32'd1);
      @(posedge clk);
      #1;

      // Unsigned issue and signed values
      run_one("u100_7",   1'b0, 8'd100, 8'd7,  4'd5, 8'd14,  8'd2,  1'b0, 1'b0);
      run_one("sm100_7",  1'b1, 8'h9C,  8'd7,  4'd1, 8'hF2,  8'hFE, 1'b0, 1'b0);
      run_one("s100_m7",  1'b1, 8'd100, 8'hF9, 4'd2, 8'hF2,  8'h02, 1'b0, 1'b0);
      // Special cases
      run_one("div0",     1'b0, 8'h55,  8'h00, 4'd3, 8'hFF,  8'h55, 1'b1, 1'b0);
      run_one("div0_s",   1'b1, 8'h80,  8'h00, 4'd9, 8'hFF,  8'h80, 1'b1, 1'b0);
      run_one("s_ovf",    1'b1, 8'h80,  8'hFF, 4'd4, 8'h80,  8'h00, 1'b0, 1'b1);
      run_one("u80_ff",   1'b0, 8'h80,  8'hFF, 4'd6, 8'h00,  8'h80, 1'b0, 1'b0);

      backpressure();

      // Reset with three operations in flight
      i_ready_out = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_signed = 1'b0;
         a = 8'(50 + k);
         b = 8'd3;
         i_tag = 4'(k + 1);
         i_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      check("pre_rst_valid", 32'(d3_valid), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("async_rst_valid", 32'(d3_valid), 32'd0);
      check("async_rst_q",     32'(d3_q),     32'd0);
      check("async_rst_tag",   32'(d3_tag),   32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1 check("post_rst_ready", 32'(d3_ready), 32'd1);
      repeat (6) begin
         @(negedge clk);
         check("no_stale", 32'(d3_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      run_one("u200_3", 1'b0, 8'd200, 8'd3, 4'd7, 8'd66, 8'd2, 1'b0, 1'b0);

      // Drain everything, then run the random depth sweep
      i_valid = 1'b0;
      i_ready_out = 1'b1;
      repeat (12) @(posedge clk);
      #1 sweep_on = 1'b1;
      begin
         int issued;
         issued = 0;
         while (issued < 1000 && cyc < HMAX - 20) begin
            bit v;
            int sel;
            v = ($urandom_range(0, 4) != 0);
            i_valid  = v;
            i_signed = $urandom_range(0, 1) == 1;
            a        = ($urandom_range(0, 15) == 0) ? 8'h80 : 8'($urandom);
            sel      = $urandom_range(0, 15);
            b        = (sel == 0) ? 8'h00 : ((sel == 1) ? 8'hFF : 8'($urandom));
            i_tag    = 4'($urandom);
            hist_v[cyc] = v;
            hist_s[cyc] = i_signed;
            hist_a[cyc] = a;
            hist_b[cyc] = b;
            hist_t[cyc] = i_tag;
            if (v) issued++;
            @(posedge clk);
            #1;
         end
         check("sweep_issued", 32'(issued), 32'd1000);
      end
      i_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1 sweep_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
